// File: rtl/i2cmb_seq_pkg.sv
// rtl/i2cmb_seq_pkg.sv - shared types, register map and command encodings for the IICMB sequencer
package i2cmb_seq_pkg;

    typedef enum logic [1:0] {
        CSR  = 2'd0,
        DPR  = 2'd1,
        CMDR = 2'd2,
        FSMR = 2'd3
    } iicmb_reg_t;

    typedef enum logic [2:0] {
        WRITE    = 3'b001,
        READ_ACK = 3'b010,
        READ_NAK = 3'b011,
        START    = 3'b100,
        STOP     = 3'b101,
        SET_BUS  = 3'b110
    } iicmb_cmd_t;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    // core enable plus interrupt enable
    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DPR_WR,
        ST_CMD_WR,
        ST_IRQ_WAIT,
        ST_CMD_RD,
        ST_DPR_RD,
        ST_RESP
    } seq_state_t;

    typedef enum logic [2:0] {
        STEP_SETBUS,
        STEP_START,
        STEP_ADDR,
        STEP_DATA,
        STEP_RDNAK,
        STEP_STOP
    } seq_step_t;

    typedef enum logic {
        WB_IDLE,
        WB_BUSY
    } wb_state_t;

    function automatic iicmb_cmd_t step_cmd(input seq_step_t s);
        case (s)
            STEP_SETBUS: return SET_BUS;
            STEP_START:  return START;
            STEP_ADDR:   return WRITE;
            STEP_DATA:   return WRITE;
            STEP_RDNAK:  return READ_NAK;
            default:     return STOP;
        endcase
    endfunction

    // successor of a step that completed with DON (read/write fork after ADDR)
    function automatic seq_step_t step_next(input seq_step_t s, input logic rw);
        case (s)
            STEP_SETBUS: return STEP_START;
            STEP_START:  return STEP_ADDR;
            STEP_ADDR:   return rw ? STEP_RDNAK : STEP_DATA;
            default:     return STEP_STOP;
        endcase
    endfunction

    // steps that load DPR before their CMDR write
    function automatic logic step_has_dpr(input seq_step_t s);
        return (s == STEP_SETBUS) || (s == STEP_ADDR) || (s == STEP_DATA);
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// rtl/wb_single_master.sv - single-access Wishbone master, one transfer per start
module wb_single_master
    import i2cmb_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);

    wb_state_t             state, state_next;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // state register; async reset drops cyc/stb immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= WB_IDLE;
        else         state <= state_next;
    end

    // start is only honoured when idle, so a gap cycle always follows an ack
    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE: if (start) state_next = WB_BUSY;
            WB_BUSY: if (ack_i) state_next = WB_IDLE;
            default: state_next = WB_IDLE;
        endcase
    end

    // bus controls follow the state; read data is forwarded in the ack cycle
    always_comb begin
        cyc_o = (state == WB_BUSY);
        stb_o = (state == WB_BUSY);
        we_o  = we_q;
        adr_o = adr_q;
        dat_o = wdata_q;
        done  = (state == WB_BUSY) && ack_i;
        rdata = done ? dat_i : rdata_q;
    end

    // hold the access attributes for the whole access, clear them after the ack
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == WB_IDLE && start) begin
            we_q    <= we;
            adr_q   <= adr;
            wdata_q <= wdata;
        end else if (done) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= dat_i;
        end
    end

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// rtl/i2cmb_wb_sequencer.sv - runs one-byte I2C transfers as IICMB register sequences over Wishbone
module i2cmb_wb_sequencer
    import i2cmb_seq_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int BUS_ID_WIDTH   = 4,
    parameter int TIMEOUT_CYC    = 1_000_000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_rw_i,
    input  logic [BUS_ID_WIDTH-1:0]   req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]                req_wdata_i,
    output logic                      rsp_valid_o,
    output logic [7:0]                rsp_rdata_o,
    output logic                      rsp_nak_o,
    output logic                      rsp_err_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);

    seq_state_t                state, state_next;
    seq_step_t                 step, step_d;
    logic                      set_err, set_nak, nak_hit;
    logic                      rw_q, err_q, nak_q;
    logic [BUS_ID_WIDTH-1:0]   bus_q;
    logic [I2C_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                wdata_q, rdata_q;
    logic [TW-1:0]             timer;
    logic [WB_DATA_WIDTH-1:0]  dpr_val;

    logic                      wb_start, wb_we, wb_done;
    iicmb_reg_t                wb_adr;
    logic [WB_DATA_WIDTH-1:0]  wb_wdata, wb_rdata;

    wb_single_master #(
        .ADDR_WIDTH (WB_ADDR_WIDTH),
        .DATA_WIDTH (WB_DATA_WIDTH)
    ) u_wb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (wb_start),
        .we     (wb_we),
        .adr    (WB_ADDR_WIDTH'(wb_adr)),
        .wdata  (wb_wdata),
        .done   (wb_done),
        .rdata  (wb_rdata),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i)
    );

    // a NAK only matters on bytes we put on the bus ourselves
    assign nak_hit = wb_rdata[CMDR_NAK] && (step == STEP_ADDR || step == STEP_DATA);

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_INIT;
        else         state <= state_next;
    end

    // sequencing and CMDR status decisions (AL > ERR > NAK > DON)
    always_comb begin
        state_next = state;
        step_d     = step;
        set_err    = 1'b0;
        set_nak    = 1'b0;
        case (state)
            ST_INIT:   if (wb_done) state_next = ST_IDLE;
            ST_IDLE:   if (req_valid_i) begin
                state_next = ST_DPR_WR;
                step_d     = STEP_SETBUS;
            end
            ST_DPR_WR: if (wb_done) state_next = ST_CMD_WR;
            ST_CMD_WR: if (wb_done) state_next = ST_IRQ_WAIT;
            ST_IRQ_WAIT: begin
                if (irq_i) begin
                    state_next = ST_CMD_RD;
                end else if (timer == T_LAST) begin
                    state_next = ST_RESP;
                    set_err    = 1'b1;
                end
            end
            ST_CMD_RD: if (wb_done) begin
                if (wb_rdata[CMDR_AL]) begin
                    // core already released the bus, a STOP would be meaningless
                    set_err    = 1'b1;
                    state_next = ST_RESP;
                end else if (wb_rdata[CMDR_ERR] || (!nak_hit && !wb_rdata[CMDR_DON])) begin
                    set_err    = 1'b1;
                    state_next = (step == STEP_STOP) ? ST_RESP : ST_CMD_WR;
                    step_d     = STEP_STOP;
                end else if (nak_hit) begin
                    set_nak    = 1'b1;
                    step_d     = STEP_STOP;
                    state_next = ST_CMD_WR;
                end else if (step == STEP_RDNAK) begin
                    state_next = ST_DPR_RD;
                end else if (step == STEP_STOP) begin
                    state_next = ST_RESP;
                end else begin
                    step_d     = step_next(step, rw_q);
                    state_next = step_has_dpr(step_d) ? ST_DPR_WR : ST_CMD_WR;
                end
            end
            ST_DPR_RD: if (wb_done) begin
                step_d     = STEP_STOP;
                state_next = ST_CMD_WR;
            end
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_INIT;
        endcase
    end

    // DPR payload for the current step
    always_comb begin
        case (step)
            STEP_SETBUS: dpr_val = WB_DATA_WIDTH'(bus_q);
            STEP_ADDR:   dpr_val = WB_DATA_WIDTH'({addr_q, rw_q});
            default:     dpr_val = WB_DATA_WIDTH'(wdata_q);
        endcase
    end

    // Wishbone access requests and handshake/response outputs per state
    always_comb begin
        wb_start    = 1'b0;
        wb_we       = 1'b0;
        wb_adr      = CSR;
        wb_wdata    = '0;
        case (state)
            ST_INIT:   begin wb_start = 1'b1; wb_we = 1'b1; wb_adr = CSR;  wb_wdata = WB_DATA_WIDTH'(CSR_ENABLE); end
            ST_DPR_WR: begin wb_start = 1'b1; wb_we = 1'b1; wb_adr = DPR;  wb_wdata = dpr_val; end
            ST_CMD_WR: begin wb_start = 1'b1; wb_we = 1'b1; wb_adr = CMDR; wb_wdata = WB_DATA_WIDTH'(step_cmd(step)); end
            ST_CMD_RD: begin wb_start = 1'b1; wb_adr = CMDR; end
            ST_DPR_RD: begin wb_start = 1'b1; wb_adr = DPR; end
            default:   ;
        endcase
        req_ready_o = (state == ST_IDLE);
        rsp_valid_o = (state == ST_RESP);
        rsp_rdata_o = (rsp_valid_o && !err_q && !nak_q) ? rdata_q : 8'h00;
        rsp_nak_o   = rsp_valid_o && nak_q;
        rsp_err_o   = rsp_valid_o && err_q;
    end

    // request latch, status flags, read byte and irq timeout counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step    <= STEP_SETBUS;
            rw_q    <= 1'b0;
            bus_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            nak_q   <= 1'b0;
            timer   <= '0;
        end else begin
            step <= step_d;
            if (state == ST_IDLE && req_valid_i) begin
                rw_q    <= req_rw_i;
                bus_q   <= req_bus_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                err_q   <= 1'b0;
                nak_q   <= 1'b0;
            end else begin
                if (set_err) err_q <= 1'b1;
                if (set_nak) nak_q <= 1'b1;
                if (state == ST_DPR_RD && wb_done) rdata_q <= wb_rdata[7:0];
            end
            if (state == ST_CMD_WR)
                timer <= '0;
            else if (state == ST_IRQ_WAIT && !irq_i && timer != T_MAX)
                timer <= timer + TW'(1);
        end
    end

endmodule
